// File: rtl/fifo_rd_stream_if.sv
// Read-port and output-stream bundle for fifo_rd_stream.
// FIFO_RD_STATS_EN adds the rd_beats/rd_drops counters to both modports.
interface fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             rempty;
    logic [WIDTH-1:0] rdata;
    logic             rinc;
    logic             flush;
    logic             flush_busy;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [1:0]       buf_cnt;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]      rd_beats;
    logic [15:0]      rd_drops;

    modport master (
        input  rempty, rdata, flush, m_ready,
        output rinc, flush_busy, m_valid, m_data, buf_cnt, rd_beats, rd_drops
    );
    modport slave (
        output rempty, rdata, flush, m_ready,
        input  rinc, flush_busy, m_valid, m_data, buf_cnt, rd_beats, rd_drops
    );
`else
    modport master (
        input  rempty, rdata, flush, m_ready,
        output rinc, flush_busy, m_valid, m_data, buf_cnt
    );
    modport slave (
        output rempty, rdata, flush, m_ready,
        input  rinc, flush_busy, m_valid, m_data, buf_cnt
    );
`endif
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO into a 3-entry buffer and streams it out.
// Optional handshake/drop statistics are enabled with FIFO_RD_STATS_EN.
module fifo_rd_stream #(
    parameter int WIDTH = 8
) (
    input  logic              rclk,
    input  logic              rrst,
    fifo_rd_stream_if.master  bus
);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    state_t           state_r;
    logic             inflight_r;
    logic [WIDTH-1:0] mem_r [3];
    logic [1:0]       rd_ptr_r;
    logic [1:0]       wr_ptr_r;
    logic [1:0]       buf_cnt_r;
    logic [1:0]       streak_r;

    logic [2:0]       credit_s;
    logic             rinc_s;
    logic             m_valid_s;
    logic             hs_s;
    logic             pop_s;
    logic [WIDTH-1:0] m_data_s;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop credit, stream handshake and output word selection.
    always_comb begin
        credit_s  = {1'b0, buf_cnt_r} + {2'b00, inflight_r};
        m_valid_s = (state_r == ST_RUN) && (buf_cnt_r != 2'd0);
        hs_s      = m_valid_s && bus.m_ready;
        // Credit counts the word already in flight so a capture always finds a free entry.
        if (rrst) begin
            rinc_s = 1'b0;
        end else if (state_r == ST_FLUSH) begin
            rinc_s = 1'b1;
        end else begin
            rinc_s = (credit_s < 3'd3);
        end
        pop_s = rinc_s && !bus.rempty;
        case (rd_ptr_r)
            2'd0:    m_data_s = mem_r[0];
            2'd1:    m_data_s = mem_r[1];
            2'd2:    m_data_s = mem_r[2];
            default: m_data_s = {WIDTH{1'b0}};
        endcase
    end

    // Main state machine: buffer bookkeeping, flush entry and empty-streak exit.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r    <= ST_RUN;
            inflight_r <= 1'b0;
            rd_ptr_r   <= 2'd0;
            wr_ptr_r   <= 2'd0;
            buf_cnt_r  <= 2'd0;
            streak_r   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            inflight_r <= pop_s;
            case (state_r)
                ST_RUN: begin
                    if (bus.flush) begin
                        state_r   <= ST_FLUSH;
                        rd_ptr_r  <= 2'd0;
                        wr_ptr_r  <= 2'd0;
                        buf_cnt_r <= 2'd0;
                        streak_r  <= 2'd0;
                    end else begin
                        state_r  <= ST_RUN;
                        streak_r <= 2'd0;
                        if (inflight_r) begin
                            mem_r[wr_ptr_r] <= bus.rdata;
                            wr_ptr_r        <= ptr_inc(wr_ptr_r);
                        end
                        if (hs_s) begin
                            rd_ptr_r <= ptr_inc(rd_ptr_r);
                        end
                        buf_cnt_r <= buf_cnt_r + {1'b0, inflight_r} - {1'b0, hs_s};
                    end
                end
                ST_FLUSH: begin
                    // rempty may lag a write by a sync stage, so demand two clean samples.
                    if (streak_r == 2'd2) begin
                        state_r  <= ST_RUN;
                        streak_r <= 2'd0;
                    end else if (bus.rempty && !inflight_r) begin
                        streak_r <= streak_r + 2'd1;
                    end else begin
                        streak_r <= 2'd0;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.rinc       = rinc_s;
    assign bus.m_valid    = m_valid_s;
    assign bus.m_data     = m_data_s;
    assign bus.buf_cnt    = buf_cnt_r;
    assign bus.flush_busy = (state_r == ST_FLUSH);

`ifdef FIFO_RD_STATS_EN
    logic [15:0] beats_r;
    logic [15:0] drops_r;
    logic [2:0]  drop_add_s;

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [2:0] a);
        logic [16:0] s;
        s = {1'b0, v} + {14'd0, a};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Words lost to flush: buffer contents at entry plus every word landing while flushing.
    always_comb begin
        if (state_r == ST_RUN && bus.flush) begin
            drop_add_s = {1'b0, buf_cnt_r} - {2'b00, hs_s} + {2'b00, inflight_r};
        end else if (state_r == ST_FLUSH) begin
            drop_add_s = {2'b00, inflight_r};
        end else begin
            drop_add_s = 3'd0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            beats_r <= 16'd0;
            drops_r <= 16'd0;
        end else begin
            beats_r <= sat_add16(beats_r, {2'b00, hs_s});
            drops_r <= sat_add16(drops_r, drop_add_s);
        end
    end

    assign bus.rd_beats = beats_r;
    assign bus.rd_drops = drops_r;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: FIFO read-port model plus an expected-word queue.
module tb_fifo_rd_stream;
    localparam int WIDTH = 8;

    logic clk  = 1'b0;
    logic rrst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.WIDTH(WIDTH)) ifc ();
    fifo_rd_stream #(.WIDTH(WIDTH)) dut (.rclk(clk), .rrst(rrst), .bus(ifc));

    logic [7:0] src [0:63];
    int         wr_cnt  = 0;
    int         rd_idx  = 0;
    int         pop_cnt = 0;
    logic [7:0] exp_q [$];
    int         total = 0;
    int         bad   = 0;

    // FIFO read port with registered data; rempty follows the write count one edge late.
    always @(posedge clk) begin
        if (ifc.rinc && !ifc.rempty) begin
            ifc.rdata <= src[rd_idx];
            rd_idx    <= rd_idx + 1;
            pop_cnt   <= pop_cnt + 1;
        end
        ifc.rempty <= ((rd_idx + ((ifc.rinc && !ifc.rempty) ? 1 : 0)) >= wr_cnt);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input bit delivered);
        src[wr_cnt] = d;
        wr_cnt++;
        if (delivered) exp_q.push_back(d);
    endtask

    // One clock: scoreboard check at the falling edge, then step to just after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (!rrst && ifc.m_valid && ifc.m_ready) begin
            chk("sb_avail", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_data", {24'd0, ifc.m_data}, {24'd0, e});
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        logic [15:0] b0;
        logic [15:0] d0;
        b0 = 16'd0;
        d0 = 16'd0;
        ifc.flush   = 1'b0;
        ifc.m_ready = 1'b0;
        rrst        = 1'b1;
        tick();
        tick();
        chk("rst_rinc",    {31'd0, ifc.rinc},       32'd0);
        chk("rst_m_valid", {31'd0, ifc.m_valid},    32'd0);
        chk("rst_buf_cnt", {30'd0, ifc.buf_cnt},    32'd0);
        chk("rst_busy",    {31'd0, ifc.flush_busy}, 32'd0);
        chk("rst_m_data",  {24'd0, ifc.m_data},     32'd0);
        rrst = 1'b0;

        // Empty FIFO: nothing popped, nothing presented.
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t1_pops",    pop_cnt,                   32'd0);
        chk("t1_m_valid", {31'd0, ifc.m_valid},    32'd0);
        chk("t1_buf_cnt", {30'd0, ifc.buf_cnt},    32'd0);
        chk("t1_busy",    {31'd0, ifc.flush_busy}, 32'd0);

        // Streaming at full rate with two-cycle first-word latency.
        p0 = pop_cnt;
        for (int k = 0; k < 5; k++) push_word(8'h11 + k[7:0], 1'b1);
        for (int i = 0; i < 10 && pop_cnt == p0; i++) tick();
        chk("t2_first_pop", pop_cnt - p0, 32'd1);
        chk("t2_lat_n1", {31'd0, ifc.m_valid}, 32'd0);
        tick();
        chk("t2_lat_n2", {31'd0, ifc.m_valid}, 32'd1);
        chk("t2_first_data", {24'd0, ifc.m_data}, 32'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_valid_run", {31'd0, ifc.m_valid}, 32'd1);
        end
        chk("t2_pops_b2b", pop_cnt - p0, 32'd5);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        chk("t2_drained", exp_q.size(), 32'd0);

        // Back-pressure: buffer fills to three, then drains in order.
        ifc.m_ready = 1'b0;
        p0 = pop_cnt;
        for (int k = 0; k < 8; k++) push_word(8'h21 + k[7:0], 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_pops_full", pop_cnt - p0, 32'd3);
        chk("t3_buf_cnt",   {30'd0, ifc.buf_cnt}, 32'd3);
        chk("t3_rinc",      {31'd0, ifc.rinc},    32'd0);
        chk("t3_m_valid",   {31'd0, ifc.m_valid}, 32'd1);
        chk("t3_hold_data", {24'd0, ifc.m_data},  32'h21);
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        chk("t3_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t3_pops_all", pop_cnt - p0, 32'd8);
        chk("t3_buf_empty", {30'd0, ifc.buf_cnt}, 32'd0);

        // Flush with two buffered words and four more arriving in the FIFO.
        ifc.m_ready = 1'b0;
        p0 = pop_cnt;
        push_word(8'h31, 1'b0);
        push_word(8'h32, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t4_buf_cnt", {30'd0, ifc.buf_cnt}, 32'd2);
        chk("t4_pre_pops", pop_cnt - p0, 32'd2);
`ifdef FIFO_RD_STATS_EN
        b0 = ifc.rd_beats;
`endif
        p0 = pop_cnt;
        for (int k = 0; k < 4; k++) push_word(8'h41 + k[7:0], 1'b0);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("t4_m_valid", {31'd0, ifc.m_valid},    32'd0);
        chk("t4_busy",    {31'd0, ifc.flush_busy}, 32'd1);
        chk("t4_cleared", {30'd0, ifc.buf_cnt},    32'd0);
        for (int i = 0; i < 30 && ifc.flush_busy; i++) tick();
        chk("t4_exit", {31'd0, ifc.flush_busy}, 32'd0);
        chk("t4_flush_pops", pop_cnt - p0, 32'd4);
`ifdef FIFO_RD_STATS_EN
        chk("t4_drops", {16'd0, ifc.rd_drops}, 32'd6);
        chk("t4_beats", {16'd0, ifc.rd_beats}, {16'd0, b0});
`endif

        // Reset with two buffered words and one in flight.
        p0 = pop_cnt;
        push_word(8'h51, 1'b0);
        push_word(8'h52, 1'b0);
        push_word(8'h53, 1'b0);
        for (int i = 0; i < 10 && ifc.buf_cnt != 2'd2; i++) tick();
        chk("t5_buf_cnt", {30'd0, ifc.buf_cnt}, 32'd2);
        chk("t5_inflight_pops", pop_cnt - p0, 32'd3);
        rrst = 1'b1;
        tick();
        chk("t5_rst_buf",   {30'd0, ifc.buf_cnt}, 32'd0);
        chk("t5_rst_valid", {31'd0, ifc.m_valid}, 32'd0);
        chk("t5_rst_rinc",  {31'd0, ifc.rinc},    32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("t5_rst_beats", {16'd0, ifc.rd_beats}, 32'd0);
        chk("t5_rst_drops", {16'd0, ifc.rd_drops}, 32'd0);
`endif
        rrst = 1'b0;
        for (int k = 0; k < 3; k++) push_word(8'h61 + k[7:0], 1'b1);
        ifc.m_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        chk("t5_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_idle", {31'd0, ifc.m_valid}, 32'd0);

        // Flush in the same cycle as a handshake: that word still counts as delivered.
        ifc.m_ready = 1'b0;
        push_word(8'h71, 1'b1);
        push_word(8'h72, 1'b0);
        push_word(8'h73, 1'b0);
        for (int i = 0; i < 10 && ifc.buf_cnt != 2'd3; i++) tick();
        chk("t6_buf_cnt", {30'd0, ifc.buf_cnt}, 32'd3);
`ifdef FIFO_RD_STATS_EN
        b0 = ifc.rd_beats;
        d0 = ifc.rd_drops;
`endif
        ifc.m_ready = 1'b1;
        ifc.flush   = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("t6_m_valid", {31'd0, ifc.m_valid},    32'd0);
        chk("t6_busy",    {31'd0, ifc.flush_busy}, 32'd1);
        chk("t6_cleared", {30'd0, ifc.buf_cnt},    32'd0);
        chk("t6_hs_done", exp_q.size(), 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("t6_beats", {16'd0, ifc.rd_beats}, {16'd0, b0 + 16'd1});
        chk("t6_drops", {16'd0, ifc.rd_drops}, {16'd0, d0 + 16'd2});
`endif
        for (int i = 0; i < 30 && ifc.flush_busy; i++) tick();
        chk("t6_exit", {31'd0, ifc.flush_busy}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle", {31'd0, ifc.m_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
